// File: rtl/pixmux_pkg.sv
// Shared types and helpers for the pixel select mux with scan sequencer.
package pixmux_pkg;

    localparam int PIX_W_DEF = 10;
    localparam int N_CH_DEF  = 28;

    // Upper bounds for the generic channel extractor below.
    localparam int FLAT_MAX = 1024;
    localparam int PIX_MAX  = 32;

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    function automatic logic [PIX_MAX-1:0] pix_at(
        input logic [FLAT_MAX-1:0] flat,
        input int                  idx,
        input int                  pix_w
    );
        return PIX_MAX'(flat >> (idx * pix_w));
    endfunction

endpackage

// File: rtl/pixmux_seq_out_reg.sv
// Registered valid/ready output stage; a load is only issued when the slot is free.
module pix_out_reg #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         out_ready,
    output logic [W-1:0] dout,
    output logic         out_valid,
    output logic         slot_free
);

    assign slot_free = !out_valid | out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            dout      <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            dout      <= din;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pixmux_seq.sv
// Pixel select mux: direct per-request selection or an autonomous channel-range scan,
// delivered through a registered valid/ready stage with a sticky error flag.
module pixmux_seq
    import pixmux_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF,
    parameter int N_CH  = N_CH_DEF,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH*PIX_W-1:0] pix_in,
    input  logic [SEL_W-1:0]  sel,
    input  logic              sel_valid,
    output logic              sel_ready,
    input  logic              start,
    input  logic [SEL_W-1:0]  scan_first,
    input  logic [SEL_W-1:0]  scan_last,
    output logic              busy,
    output logic [PIX_W-1:0]  out_pix,
    output logic [SEL_W-1:0]  out_ch,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              err,
    input  logic              err_clr
);

    localparam int PAY_W = PIX_W + SEL_W + 1;

    state_t             state, state_n;
    logic [SEL_W-1:0]   cnt, cnt_n;
    logic [SEL_W-1:0]   last_q, last_n;
    logic               load, load_last, err_set, slot_free;
    logic [SEL_W-1:0]   load_ch;
    logic [PIX_W-1:0]   load_pix;
    logic [FLAT_MAX-1:0] flat_ext;
    logic [PAY_W-1:0]   pay_out;
    logic               range_ok, sel_ok;

    assign range_ok = (scan_first <= scan_last) && (int'(scan_last) < N_CH);
    assign sel_ok   = int'(sel) < N_CH;
    assign busy     = (state == SCAN);

    always_comb begin
        flat_ext = '0;
        flat_ext[N_CH*PIX_W-1:0] = pix_in;
    end

    assign load_pix = PIX_W'(pix_at(flat_ext, int'(load_ch), PIX_W));

    // start wins over a same-cycle direct request; an illegal range only flags err.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        last_n    = last_q;
        load      = 1'b0;
        load_ch   = '0;
        load_last = 1'b0;
        err_set   = 1'b0;
        sel_ready = 1'b0;
        case (state)
            IDLE: begin
                sel_ready = slot_free & !start;
                if (start) begin
                    if (range_ok) begin
                        cnt_n   = scan_first;
                        last_n  = scan_last;
                        state_n = SCAN;
                    end else begin
                        err_set = 1'b1;
                    end
                end else if (sel_valid && slot_free) begin
                    load    = 1'b1;
                    load_ch = sel_ok ? sel : '0;
                    err_set = !sel_ok;
                end
            end
            SCAN: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_ch   = cnt;
                    load_last = (cnt == last_q);
                    if (cnt == last_q) begin
                        state_n = IDLE;
                    end else begin
                        cnt_n = cnt + SEL_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            last_q <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            last_q <= last_n;
        end
    end

    // err is set-dominant so a fault in the clearing cycle is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (err_set) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

    pix_out_reg #(
        .W(PAY_W)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .din       ({load_pix, load_ch, load_last}),
        .out_ready (out_ready),
        .dout      (pay_out),
        .out_valid (out_valid),
        .slot_free (slot_free)
    );

    assign {out_pix, out_ch, out_last} = pay_out;

endmodule

// File: tb/tb_pixmux_seq.sv
// Scoreboard bench for pixmux_seq: direct, scan, backpressure, error and reset scenarios.
module tb_pixmux_seq;

    localparam int PIX_W = 10;
    localparam int N_CH  = 28;
    localparam int SEL_W = 5;

    typedef logic [PIX_W+SEL_W:0] beat_t;

    logic                  clk;
    logic                  rst;
    logic [N_CH*PIX_W-1:0] pix_in;
    logic [SEL_W-1:0]      sel;
    logic                  sel_valid;
    logic                  sel_ready;
    logic                  start;
    logic [SEL_W-1:0]      scan_first;
    logic [SEL_W-1:0]      scan_last;
    logic                  busy;
    logic [PIX_W-1:0]      out_pix;
    logic [SEL_W-1:0]      out_ch;
    logic                  out_last;
    logic                  out_valid;
    logic                  out_ready;
    logic                  err;
    logic                  err_clr;

    logic [PIX_W-1:0] pix_ch [N_CH];
    beat_t            sb [$];
    int               n_tests = 0;
    int               n_fail  = 0;

    pixmux_seq #(
        .PIX_W (PIX_W),
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_in     (pix_in),
        .sel        (sel),
        .sel_valid  (sel_valid),
        .sel_ready  (sel_ready),
        .start      (start),
        .scan_first (scan_first),
        .scan_last  (scan_last),
        .busy       (busy),
        .out_pix    (out_pix),
        .out_ch     (out_ch),
        .out_last   (out_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .err        (err),
        .err_clr    (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic pack_pix();
        for (int k = 0; k < N_CH; k++) pix_in[k*PIX_W +: PIX_W] = pix_ch[k];
    endtask

    task automatic randomize_pix();
        for (int k = 0; k < N_CH; k++) pix_ch[k] = PIX_W'($urandom);
        pack_pix();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({out_valid, out_pix, out_ch, out_last} !== '0)
            $display("[TB] FAIL reset_out: got %h expected 0", {out_valid, out_pix, out_ch, out_last});
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        n_tests++;
        if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
        n_tests++;
        if (sel_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_sel_ready: got %b expected 1", sel_ready); end
        if ({out_valid, out_pix, out_ch, out_last} !== '0) n_fail++;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_direct();
        int    sels [4] = '{5, 0, 27, 13};
        beat_t exp_b;
        beat_t got;
        randomize_pix();
        pix_ch[5] = 10'h2A5;
        pack_pix();
        sb.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            sel_valid = (i < 4);
            sel       = (i < 4) ? SEL_W'(sels[i]) : '0;
            @(negedge clk);
            n_tests++;
            if (out_valid !== (i >= 1 && i <= 4)) begin
                n_fail++;
                $display("[TB] FAIL direct_valid[%0d]: got %b expected %b", i, out_valid, (i >= 1 && i <= 4));
            end
            if (out_valid && out_ready) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL direct_extra: got beat ch %0d expected none", out_ch);
                end else begin
                    exp_b = sb.pop_front();
                    got   = {out_pix, out_ch, out_last};
                    if (got !== exp_b) begin
                        n_fail++;
                        $display("[TB] FAIL direct_beat: got %h expected %h", got, exp_b);
                    end
                end
            end
            if (i < 4) begin
                n_tests++;
                if (sel_ready !== 1'b1) begin
                    n_fail++;
                    $display("[TB] FAIL direct_sel_ready[%0d]: got %b expected 1", i, sel_ready);
                end
                if (sel_valid && sel_ready) sb.push_back({pix_ch[sels[i]], SEL_W'(sels[i]), 1'b0});
            end
        end
        n_tests++;
        if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL direct_err: got %b expected 0", err); end
    endtask

    task automatic test_scan(input int first, input int last, input bit stall, input bit collide);
        int    n = last - first + 1;
        int    c;
        beat_t exp_b;
        beat_t got;
        beat_t prev = '0;
        bit    prev_stall = 1'b0;
        bit    exp_v;
        randomize_pix();
        sb.delete();
        for (int k = first; k <= last; k++) sb.push_back({pix_ch[k], SEL_W'(k), (k == last)});
        @(posedge clk); #1;
        scan_first = SEL_W'(first);
        scan_last  = SEL_W'(last);
        start      = 1'b1;
        sel_valid  = collide;
        sel        = SEL_W'(3);
        out_ready  = 1'b1;
        @(negedge clk);
        n_tests++;
        if (sel_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL scan_start_sel_ready: got %b expected 0", sel_ready); end
        for (c = 1; c < 200 && sb.size() > 0; c++) begin
            @(posedge clk); #1;
            start     = 1'b0;
            sel_valid = 1'b0;
            out_ready = stall ? ((c % 4 == 0) || (c % 4 == 1)) : 1'b1;
            @(negedge clk);
            got = {out_pix, out_ch, out_last};
            if (!stall) begin
                exp_v = (c >= 2 && c <= n + 1);
                n_tests++;
                if (out_valid !== exp_v) begin
                    n_fail++;
                    $display("[TB] FAIL scan_valid[%0d]: got %b expected %b", c, out_valid, exp_v);
                end
            end
            if (prev_stall) begin
                n_tests++;
                if (out_valid !== 1'b1 || got !== prev) begin
                    n_fail++;
                    $display("[TB] FAIL scan_hold: got %b/%h expected 1/%h", out_valid, got, prev);
                end
            end
            if (out_valid) begin
                n_tests++;
                if (busy !== !out_last) begin
                    n_fail++;
                    $display("[TB] FAIL scan_busy: got %b expected %b", busy, !out_last);
                end
            end
            if (out_valid && out_ready) begin
                exp_b = sb.pop_front();
                n_tests++;
                if (got !== exp_b) begin
                    n_fail++;
                    $display("[TB] FAIL scan_beat: got %h expected %h", got, exp_b);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev       = got;
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL scan_timeout: got %0d beats left expected 0", sb.size());
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL scan_end: got valid %b busy %b expected 0 0", out_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        int    n = 3;
        int    m = 2;
        beat_t exp_b;
        beat_t got;
        bit    exp_v;
        randomize_pix();
        sb.delete();
        for (int k = 2; k <= 4; k++) sb.push_back({pix_ch[k], SEL_W'(k), (k == 4)});
        for (int k = 7; k <= 8; k++) sb.push_back({pix_ch[k], SEL_W'(k), (k == 8)});
        @(posedge clk); #1;
        scan_first = SEL_W'(2);
        scan_last  = SEL_W'(4);
        start      = 1'b1;
        out_ready  = 1'b1;
        for (int c = 1; c <= n + m + 3; c++) begin
            @(posedge clk); #1;
            start = (c == n + 1);
            if (c == n + 1) begin
                scan_first = SEL_W'(7);
                scan_last  = SEL_W'(8);
            end
            @(negedge clk);
            exp_v = (c >= 2 && c <= n + 1) || (c >= n + 3 && c <= n + m + 2);
            n_tests++;
            if (out_valid !== exp_v) begin
                n_fail++;
                $display("[TB] FAIL b2b_valid[%0d]: got %b expected %b", c, out_valid, exp_v);
            end
            if (c == n + 1) begin
                n_tests++;
                if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_busy: got %b expected 0", busy); end
            end
            if (out_valid && out_ready && sb.size() > 0) begin
                exp_b = sb.pop_front();
                got   = {out_pix, out_ch, out_last};
                n_tests++;
                if (got !== exp_b) begin
                    n_fail++;
                    $display("[TB] FAIL b2b_beat: got %h expected %h", got, exp_b);
                end
            end
        end
        start = 1'b0;
        n_tests++;
        if (sb.size() != 0) begin n_fail++; $display("[TB] FAIL b2b_left: got %0d expected 0", sb.size()); end
    endtask

    task automatic test_err_direct();
        beat_t got;
        beat_t exp_b;
        randomize_pix();
        out_ready = 1'b1;
        @(posedge clk); #1;
        sel       = SEL_W'(30);
        sel_valid = 1'b1;
        @(negedge clk);
        n_tests++;
        if (sel_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL err_sel_ready: got %b expected 1", sel_ready); end
        exp_b = {pix_ch[0], SEL_W'(0), 1'b0};
        @(posedge clk); #1;
        sel_valid = 1'b0;
        @(negedge clk);
        got = {out_pix, out_ch, out_last};
        n_tests++;
        if (out_valid !== 1'b1 || got !== exp_b) begin
            n_fail++;
            $display("[TB] FAIL err_oor_beat: got %b/%h expected 1/%h", out_valid, got, exp_b);
        end
        n_tests++;
        if (err !== 1'b1) begin n_fail++; $display("[TB] FAIL err_set: got %b expected 1", err); end
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        n_tests++;
        if (err !== 1'b1) begin n_fail++; $display("[TB] FAIL err_sticky: got %b expected 1", err); end
        @(posedge clk); #1;
        sel       = SEL_W'(31);
        sel_valid = 1'b1;
        err_clr   = 1'b1;
        @(posedge clk); #1;
        sel_valid = 1'b0;
        err_clr   = 1'b0;
        @(negedge clk);
        n_tests++;
        if (err !== 1'b1) begin n_fail++; $display("[TB] FAIL err_set_dominant: got %b expected 1", err); end
        @(posedge clk); #1;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        @(negedge clk);
        n_tests++;
        if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL err_clear: got %b expected 0", err); end
    endtask

    task automatic test_bad_range();
        int firsts [2] = '{10, 0};
        int lasts  [2] = '{4, 28};
        out_ready = 1'b1;
        for (int t = 0; t < 2; t++) begin
            @(posedge clk); #1;
            scan_first = SEL_W'(firsts[t]);
            scan_last  = SEL_W'(lasts[t]);
            start      = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                n_tests++;
                if (out_valid !== 1'b0 || busy !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL bad_range_quiet[%0d]: got valid %b busy %b expected 0 0", t, out_valid, busy);
                end
                @(posedge clk); #1;
            end
            @(negedge clk);
            n_tests++;
            if (err !== 1'b1) begin n_fail++; $display("[TB] FAIL bad_range_err[%0d]: got %b expected 1", t, err); end
            @(posedge clk); #1;
            err_clr = 1'b1;
            @(posedge clk); #1;
            err_clr = 1'b0;
        end
    endtask

    task automatic test_reset_mid_scan();
        beat_t exp_b;
        beat_t got;
        randomize_pix();
        sb.delete();
        for (int k = 0; k < N_CH; k++) sb.push_back({pix_ch[k], SEL_W'(k), (k == N_CH - 1)});
        @(posedge clk); #1;
        scan_first = SEL_W'(0);
        scan_last  = SEL_W'(N_CH - 1);
        start      = 1'b1;
        out_ready  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        exp_b = sb.pop_front();
        got   = {out_pix, out_ch, out_last};
        n_tests++;
        if (out_valid !== 1'b1 || got !== exp_b) begin
            n_fail++;
            $display("[TB] FAIL rst_scan_first: got %b/%h expected 1/%h", out_valid, got, exp_b);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rst_abort: got valid %b busy %b expected 0 0", out_valid, busy);
        end
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        sel       = SEL_W'(1);
        sel_valid = 1'b1;
        @(negedge clk);
        n_tests++;
        if (sel_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_sel_ready: got %b expected 1", sel_ready); end
        exp_b = {pix_ch[1], SEL_W'(1), 1'b0};
        @(posedge clk); #1;
        sel_valid = 1'b0;
        @(negedge clk);
        got = {out_pix, out_ch, out_last};
        n_tests++;
        if (out_valid !== 1'b1 || got !== exp_b || err !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rst_direct: got %b/%h err %b expected 1/%h err 0", out_valid, got, err, exp_b);
        end
    endtask

    initial begin
        rst        = 1'b1;
        pix_in     = '0;
        sel        = '0;
        sel_valid  = 1'b0;
        start      = 1'b0;
        scan_first = '0;
        scan_last  = '0;
        out_ready  = 1'b0;
        err_clr    = 1'b0;
        for (int k = 0; k < N_CH; k++) pix_ch[k] = '0;

        test_reset();
        test_direct();
        test_scan(3, 6, 1'b0, 1'b0);
        test_scan(3, 6, 1'b1, 1'b0);
        test_scan(9, 9, 1'b0, 1'b0);
        test_scan(25, 27, 1'b1, 1'b0);
        test_back_to_back();
        test_err_direct();
        test_bad_range();
        test_scan(20, 21, 1'b0, 1'b1);
        test_reset_mid_scan();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
